// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpu_pkg
// Description : Shared miniGPU definitions: core sequencer state encodings
//               and the thread-count clamp helper.
// Revision    : 1.0 - initial release
// ============================================================================
package gpu_pkg;

  localparam int CORE_STATE_BITS = 3;

  localparam logic [CORE_STATE_BITS-1:0] ST_IDLE    = 3'd0;
  localparam logic [CORE_STATE_BITS-1:0] ST_FETCH   = 3'd1;
  localparam logic [CORE_STATE_BITS-1:0] ST_DECODE  = 3'd2;
  localparam logic [CORE_STATE_BITS-1:0] ST_REQUEST = 3'd3;
  localparam logic [CORE_STATE_BITS-1:0] ST_WAIT    = 3'd4;
  localparam logic [CORE_STATE_BITS-1:0] ST_EXECUTE = 3'd5;
  localparam logic [CORE_STATE_BITS-1:0] ST_UPDATE  = 3'd6;
  localparam logic [CORE_STATE_BITS-1:0] ST_DONE    = 3'd7;

  // Requested thread count limited to the lanes physically present.
  function automatic int clamp_count(input logic [7:0] count, input int max_threads);
    int c;
    c = int'({24'd0, count});
    return (c > max_threads) ? max_threads : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/simt_pc_select.sv
`default_nettype none
// ============================================================================
// Module      : simt_pc_select
// Description : Picks the PC of the lowest-index live lane and flags every
//               live lane whose PC equals it (the lanes of the next pass).
// Ports       : live       - lanes still running (enabled & ~done)
//               pc_flat    - per-lane PCs, lane i at [i*ADDR_BITS +: ADDR_BITS]
//               sel_pc     - selected PC (0 when no lane is live)
//               match_mask - live lanes sharing sel_pc
// Revision    : 1.0 - initial release
// ============================================================================
module simt_pc_select
  import gpu_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int ADDR_BITS   = 8
) (
  input  logic [NUM_THREADS-1:0]           live,
  input  logic [NUM_THREADS*ADDR_BITS-1:0] pc_flat,
  output logic [ADDR_BITS-1:0]             sel_pc,
  output logic [NUM_THREADS-1:0]           match_mask
);

  // Priority encoder: the first live lane found wins, so lower-index PC
  // groups are always serviced before higher ones.
  always_comb begin : p_select
    logic found;
    found  = 1'b0;
    sel_pc = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (live[i] && !found) begin
        sel_pc = pc_flat[i*ADDR_BITS +: ADDR_BITS];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    match_mask = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      match_mask[i] = live[i] && (pc_flat[i*ADDR_BITS +: ADDR_BITS] == sel_pc);
    end
  end

endmodule
`default_nettype wire

// File: rtl/simt_core_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : simt_core_ctrl
// Description : Per-core SIMT sequencer. Holds one PC and done flag per
//               thread, runs FETCH-DECODE-REQUEST-WAIT-EXECUTE-UPDATE passes
//               and services divergent PC groups on successive passes.
// Ports       : clk, reset (async, active low)
//               core_start, core_thread_count   - block launch
//               fetch_ack, decoded_ret          - fetcher / decoder status
//               lsu_busy_flat, next_pc_flat     - per-lane LSU busy, next PC
//               core_state, fetch_req, fetch_pc - sequencer state / fetch
//               active_mask, thread_pc_flat     - lanes of this pass, PCs
//               divergent, core_done            - status
// Revision    : 1.0 - initial release
// ============================================================================
module simt_core_ctrl
  import gpu_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int ADDR_BITS   = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             core_start,
  input  logic [7:0]                       core_thread_count,
  input  logic                             fetch_ack,
  input  logic                             decoded_ret,
  input  logic [NUM_THREADS-1:0]           lsu_busy_flat,
  input  logic [NUM_THREADS*ADDR_BITS-1:0] next_pc_flat,
  output logic [CORE_STATE_BITS-1:0]       core_state,
  output logic                             fetch_req,
  output logic [ADDR_BITS-1:0]             fetch_pc,
  output logic [NUM_THREADS-1:0]           active_mask,
  output logic [NUM_THREADS*ADDR_BITS-1:0] thread_pc_flat,
  output logic                             divergent,
  output logic                             core_done
);

  logic [CORE_STATE_BITS-1:0]       r_state;
  logic [NUM_THREADS-1:0]           r_enabled;
  logic [NUM_THREADS-1:0]           r_done;
  logic [NUM_THREADS*ADDR_BITS-1:0] r_pc;
  logic [ADDR_BITS-1:0]             r_fetch_pc;
  logic [NUM_THREADS-1:0]           r_active_mask;

  int                               w_thread_limit;
  logic [NUM_THREADS-1:0]           w_launch_mask;
  logic [NUM_THREADS-1:0]           w_enabled_next;
  logic [NUM_THREADS-1:0]           w_done_next;
  logic [NUM_THREADS*ADDR_BITS-1:0] w_pc_next;
  logic [NUM_THREADS-1:0]           w_live_next;
  logic [ADDR_BITS-1:0]             w_sel_pc;
  logic [NUM_THREADS-1:0]           w_match_mask;

  assign w_thread_limit = clamp_count(core_thread_count, NUM_THREADS);

  always_comb begin
    w_launch_mask = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      w_launch_mask[i] = (i < w_thread_limit);
    end
  end

  // Next-cycle thread arrays. The PC selector looks at these rather than
  // the current registers so fetch_pc/active_mask land together with the
  // launch or UPDATE write that leads into FETCH.
  always_comb begin
    w_enabled_next = r_enabled;
    w_done_next    = r_done;
    w_pc_next      = r_pc;
    if (r_state == ST_IDLE && core_start) begin
      w_enabled_next = w_launch_mask;
      w_done_next    = '0;
      w_pc_next      = '0;
    end else if (r_state == ST_UPDATE) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        if (r_active_mask[i]) begin
          if (decoded_ret) begin
            w_done_next[i] = 1'b1;
          end else begin
            w_pc_next[i*ADDR_BITS +: ADDR_BITS] = next_pc_flat[i*ADDR_BITS +: ADDR_BITS];
          end
        end
      end
    end
  end

  assign w_live_next = w_enabled_next & ~w_done_next;

  simt_pc_select #(
    .NUM_THREADS (NUM_THREADS),
    .ADDR_BITS   (ADDR_BITS)
  ) u_pc_select (
    .live       (w_live_next),
    .pc_flat    (w_pc_next),
    .sel_pc     (w_sel_pc),
    .match_mask (w_match_mask)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_enabled     <= '0;
      r_done        <= '0;
      r_pc          <= '0;
      r_fetch_pc    <= '0;
      r_active_mask <= '0;
    end else begin
      r_enabled <= w_enabled_next;
      r_done    <= w_done_next;
      r_pc      <= w_pc_next;
      case (r_state)
        ST_IDLE: begin
          if (core_start) begin
            if (w_launch_mask == '0) begin
              r_state <= ST_DONE;
            end else begin
              r_state       <= ST_FETCH;
              r_fetch_pc    <= w_sel_pc;
              r_active_mask <= w_match_mask;
            end
          end
        end
        ST_FETCH:   if (fetch_ack) r_state <= ST_DECODE;
        ST_DECODE:  r_state <= ST_REQUEST;
        ST_REQUEST: r_state <= ST_WAIT;
        // Only lanes in this pass can hold the pipeline.
        ST_WAIT:    if ((lsu_busy_flat & r_active_mask) == '0) r_state <= ST_EXECUTE;
        ST_EXECUTE: r_state <= ST_UPDATE;
        ST_UPDATE: begin
          if (w_live_next == '0) begin
            r_state <= ST_DONE;
          end else begin
            r_state       <= ST_FETCH;
            r_fetch_pc    <= w_sel_pc;
            r_active_mask <= w_match_mask;
          end
        end
        ST_DONE:    if (!core_start) r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  assign core_state     = r_state;
  assign fetch_req      = (r_state == ST_FETCH);
  assign core_done      = (r_state == ST_DONE);
  assign fetch_pc       = r_fetch_pc;
  assign active_mask    = r_active_mask;
  assign thread_pc_flat = r_pc;
  assign divergent      = (r_active_mask != (r_enabled & ~r_done));

endmodule
`default_nettype wire

// File: tb/tb_simt_core_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_simt_core_ctrl
// Description : Self-checking bench for simt_core_ctrl. A thread-level model
//               predicts every output each cycle; directed scenarios pin the
//               model with hand-computed pass sequences and timings.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simt_core_ctrl;

  localparam int NT = 4;
  localparam int AB = 8;
  localparam int S_IDLE = 0, S_FETCH = 1, S_WAIT = 4, S_UPDATE = 6, S_DONE = 7;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            core_start = 1'b0;
  logic [7:0]      count = 8'd0;
  logic            fetch_ack = 1'b0;
  logic            decoded_ret = 1'b0;
  logic [NT-1:0]   lsu_busy = '0;
  logic [NT*AB-1:0] next_pc = '0;

  logic [2:0]       core_state;
  logic             fetch_req;
  logic [AB-1:0]    fetch_pc;
  logic [NT-1:0]    active_mask;
  logic [NT*AB-1:0] thread_pc_flat;
  logic             divergent;
  logic             core_done;

  simt_core_ctrl #(.NUM_THREADS(NT), .ADDR_BITS(AB)) dut (
    .clk               (clk),
    .reset             (rst_n),
    .core_start        (core_start),
    .core_thread_count (count),
    .fetch_ack         (fetch_ack),
    .decoded_ret       (decoded_ret),
    .lsu_busy_flat     (lsu_busy),
    .next_pc_flat      (next_pc),
    .core_state        (core_state),
    .fetch_req         (fetch_req),
    .fetch_pc          (fetch_pc),
    .active_mask       (active_mask),
    .thread_pc_flat    (thread_pc_flat),
    .divergent         (divergent),
    .core_done         (core_done)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input int waited);
    n_total++;
    $display("FAIL %s: waited %0d cycles, event required within bound", name, waited);
  endtask

  // ---------------- thread-level model ----------------
  int            m_state;
  int            m_pc [NT];
  logic [NT-1:0] m_en, m_done, m_mask;
  int            m_fpc;

  task automatic model_reset();
    m_state = S_IDLE; m_en = '0; m_done = '0; m_mask = '0; m_fpc = 0;
    for (int i = 0; i < NT; i++) m_pc[i] = 0;
  endtask

  // Lowest-index live lane picks the PC; all live lanes at that PC run.
  task automatic model_select();
    int sel;
    sel = -1;
    for (int i = 0; i < NT; i++) if (sel < 0 && m_en[i] && !m_done[i]) sel = i;
    m_fpc = m_pc[sel];
    for (int i = 0; i < NT; i++) m_mask[i] = m_en[i] && !m_done[i] && (m_pc[i] == m_fpc);
  endtask

  task automatic model_step();
    int n;
    case (m_state)
      S_IDLE: if (core_start) begin
        n = (int'(count) > NT) ? NT : int'(count);
        for (int i = 0; i < NT; i++) begin
          m_en[i] = (i < n); m_done[i] = 1'b0; m_pc[i] = 0;
        end
        if (n == 0) m_state = S_DONE;
        else begin m_state = S_FETCH; model_select(); end
      end
      S_FETCH: if (fetch_ack) m_state = 2;
      2:       m_state = 3;
      3:       m_state = S_WAIT;
      S_WAIT:  if ((lsu_busy & m_mask) == '0) m_state = 5;
      5:       m_state = S_UPDATE;
      S_UPDATE: begin
        for (int i = 0; i < NT; i++) if (m_mask[i]) begin
          if (decoded_ret) m_done[i] = 1'b1;
          else m_pc[i] = int'(next_pc[i*AB +: AB]);
        end
        if ((m_en & ~m_done) == '0) m_state = S_DONE;
        else begin m_state = S_FETCH; model_select(); end
      end
      default: if (!core_start) m_state = S_IDLE;
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst_n) model_step();
    end
  end

  initial forever begin
    @(negedge rst_n);
    model_reset();
  end

  // ---------------- stimulus configuration ----------------
  int mode = 0;          // 0: uniform pc+1 program, RET at pc 2; 1: divergent program
  int ack_delay = 0;
  int busy_cycles = 0;
  logic [NT-1:0] busy_pat = '0;
  bit inactive_busy = 1'b0;

  function automatic int prog_next(input int md, input int pc, input int lane);
    if (md == 1 && pc == 1) return (lane < 2) ? 5 : 2;
    return (pc + 1) % 256;
  endfunction

  function automatic bit prog_ret(input int md, input int pc);
    if (md == 1) return (pc == 5) || (pc == 3);
    return pc == 2;
  endfunction

  // ---------------- per-pass observation ----------------
  int q_fpc[$], q_mask[$], q_div[$], q_flen[$], q_wlen[$];
  bit div_seen = 1'b0;
  int prev_st = S_IDLE, flen = 0, wlen = 0, fcnt = 0, wcnt = 0;

  task automatic compare();
    logic [NT*AB-1:0] exp_pcs;
    for (int i = 0; i < NT; i++) exp_pcs[i*AB +: AB] = m_pc[i][AB-1:0];
    chk("state", core_state, m_state);
    chk("fetch_req", fetch_req, m_state == S_FETCH);
    chk("core_done", core_done, m_state == S_DONE);
    chk("fetch_pc", fetch_pc, m_fpc);
    chk("active_mask", active_mask, m_mask);
    chk("thread_pc", thread_pc_flat, exp_pcs);
    chk("divergent", divergent, m_mask != (m_en & ~m_done));
  endtask

  task automatic monitor();
    int st;
    st = int'(core_state);
    if (prev_st == S_FETCH && st != S_FETCH) q_flen.push_back(flen);
    if (prev_st == S_WAIT && st != S_WAIT) q_wlen.push_back(wlen);
    if (st == S_FETCH && prev_st != S_FETCH) begin
      q_fpc.push_back(int'(fetch_pc)); q_mask.push_back(int'(active_mask));
      q_div.push_back(int'(divergent)); flen = 0;
    end
    if (st == S_WAIT && prev_st != S_WAIT) wlen = 0;
    if (st == S_FETCH) flen++;
    if (st == S_WAIT) wlen++;
    if (st >= S_FETCH && st <= S_UPDATE && divergent) div_seen = 1'b1;
    prev_st = st;
  endtask

  // Fetcher, decoder, pc_nzp and LSU stand-ins.
  task automatic respond();
    if (fetch_req) begin fetch_ack = (fcnt >= ack_delay); fcnt++; end
    else begin fetch_ack = 1'b0; fcnt = 0; end
    decoded_ret = prog_ret(mode, int'(fetch_pc));
    for (int i = 0; i < NT; i++) next_pc[i*AB +: AB] = 8'(prog_next(mode, int'(fetch_pc), i));
    if (int'(core_state) == S_WAIT) begin
      lsu_busy = (wcnt < busy_cycles) ? busy_pat : '0; wcnt++;
    end else begin
      lsu_busy = '0; wcnt = 0;
    end
    if (inactive_busy) lsu_busy = lsu_busy | ~active_mask;
  endtask

  initial forever begin
    @(negedge clk);
    compare();
    monitor();
    respond();
  end

  // ---------------- directed scenarios ----------------
  task automatic clear_log();
    q_fpc.delete(); q_mask.delete(); q_div.delete(); q_flen.delete(); q_wlen.delete();
    div_seen = 1'b0;
  endtask

  task automatic run_launch(input int cnt, output int cycles);
    @(negedge clk); count = cnt[7:0]; core_start = 1'b1;
    @(negedge clk); core_start = 1'b0; cycles = 1;
    while (!core_done && cycles < 400) begin @(negedge clk); cycles++; end
    if (!core_done) fail_now("launch_timeout", cycles);
    @(negedge clk);
  endtask

  task automatic wait_for(input int st, input int pc, input string name);
    int n;
    n = 0;
    while (!(int'(core_state) == st && int'(fetch_pc) == pc) && n < 200) begin
      @(negedge clk); n++;
    end
    if (n >= 200) fail_now(name, n);
  endtask

  initial begin
    int cyc;
    int ea_fpc[3], ee_fpc[5], ee_mask[5], ee_div[5];
    ea_fpc = '{0, 1, 2};
    ee_fpc = '{0, 1, 5, 2, 3};
    ee_mask = '{15, 15, 3, 12, 12};
    ee_div = '{0, 0, 1, 0, 0};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {core_state, fetch_req, fetch_pc, active_mask, thread_pc_flat,
        divergent, core_done}, 64'd0);
    #2 rst_n = 1'b1;

    // A: uniform program, 4 lanes, immediate ack
    clear_log(); mode = 0;
    run_launch(4, cyc);
    chk("A_cycles_to_done", cyc, 19);
    chk("A_pass_count", q_fpc.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("A_fetch_pc", (q_fpc.size() > i) ? q_fpc[i] : -1, ea_fpc[i]);
      chk("A_mask", (q_mask.size() > i) ? q_mask[i] : -1, 15);
    end
    chk("A_divergent_seen", div_seen, 0);
    chk("A_fetch_len", (q_flen.size() > 0) ? q_flen[0] : -1, 1);
    chk("A_state_idle", core_state, S_IDLE);

    // B: two lanes only
    clear_log();
    run_launch(2, cyc);
    chk("B_mask", (q_mask.size() > 0) ? q_mask[0] : -1, 3);
    chk("B_pcs", thread_pc_flat, 32'h0000_0202);

    // C: count above lane count clamps
    clear_log();
    run_launch(9, cyc);
    chk("C_mask", (q_mask.size() > 0) ? q_mask[0] : -1, 15);
    chk("C_cycles_to_done", cyc, 19);

    // D: zero threads goes straight to DONE
    clear_log();
    run_launch(0, cyc);
    chk("D_cycles_to_done", cyc, 1);
    chk("D_no_pass", q_fpc.size(), 0);

    // E: divergence and reconvergence; inactive lanes report busy
    clear_log(); mode = 1; inactive_busy = 1'b1;
    run_launch(4, cyc);
    chk("E_pass_count", q_fpc.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk("E_fetch_pc", (q_fpc.size() > i) ? q_fpc[i] : -1, ee_fpc[i]);
      chk("E_mask", (q_mask.size() > i) ? q_mask[i] : -1, ee_mask[i]);
      chk("E_divergent", (q_div.size() > i) ? q_div[i] : -1, ee_div[i]);
    end
    chk("E_inactive_busy_wait_len", (q_wlen.size() > 2) ? q_wlen[2] : -1, 1);
    chk("E_cycles_to_done", cyc, 31);
    chk("E_final_pcs", thread_pc_flat, 32'h0303_0505);

    // F: slow fetch ack, LSU stall, ignored start, async reset in WAIT
    clear_log(); mode = 0; inactive_busy = 1'b0;
    ack_delay = 3; busy_cycles = 4; busy_pat = 4'b0100;
    @(negedge clk); count = 8'd4; core_start = 1'b1;
    @(negedge clk); core_start = 1'b0;
    wait_for(S_FETCH, 1, "F_pass2_timeout");
    core_start = 1'b1;
    @(negedge clk); core_start = 1'b0;
    wait_for(S_WAIT, 2, "F_pass3_timeout");
    chk("F_fetch_len_1", (q_flen.size() > 0) ? q_flen[0] : -1, 4);
    chk("F_fetch_len_2", (q_flen.size() > 1) ? q_flen[1] : -1, 4);
    chk("F_wait_len", (q_wlen.size() > 0) ? q_wlen[0] : -1, 5);
    chk("F_pre_reset_pcs", thread_pc_flat, 32'h0202_0202);
    #2 rst_n = 1'b0;
    #1 chk("F_async_reset", {core_state, fetch_req, fetch_pc, active_mask, thread_pc_flat,
           divergent, core_done}, 64'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    ack_delay = 0; busy_cycles = 0;
    repeat (2) @(negedge clk);

    // G: clean relaunch after reset
    clear_log();
    run_launch(4, cyc);
    chk("G_cycles_to_done", cyc, 19);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, required finish earlier");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
